// File: rtl/apb_req_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the APB master's internal port.
// The arbiter uses the master modport; the requester/APB-master environment uses slave.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [DW-1:0]         req_rdata;
  logic                  busy;
  logic                  transfer;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         wdata;
  logic                  write;
  logic                  ready;
  logic [DW-1:0]         rdata;

  modport master (
    input  req, req_addr, req_wdata, req_write, ready, rdata,
    output gnt, done, req_rdata, busy, transfer, addr, wdata, write
  );

  modport slave (
    output req, req_addr, req_wdata, req_write, ready, rdata,
    input  gnt, done, req_rdata, busy, transfer, addr, wdata, write
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master internal port between NUM_REQ requesters,
// sequencing one transfer at a time and returning read data plus a done pulse to the owner.
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.master bus
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, SETUP, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [LW-1:0]      last, last_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [NUM_REQ-1:0] done_q, done_nxt;
  logic               transfer_q, transfer_nxt;
  logic               write_q, write_nxt;
  logic [AW-1:0]      addr_q, addr_nxt;
  logic [DW-1:0]      wdata_q, wdata_nxt;
  logic [DW-1:0]      rdata_q, rdata_nxt;

  logic               found;
  logic [LW-1:0]      win;
  logic [LW-1:0]      cand;
  logic [AW-1:0]      addr_sel;
  logic [DW-1:0]      wdata_sel;
  logic               write_sel;

  // Search starts just after the previous winner so every requester gets its turn.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = last;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = LW'((32'(last) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    write_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == LW'(i)) begin
        addr_sel  = bus.req_addr[i*AW +: AW];
        wdata_sel = bus.req_wdata[i*DW +: DW];
        write_sel = bus.req_write[i];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    gnt_nxt      = gnt_q;
    done_nxt     = '0;
    transfer_nxt = 1'b0;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    write_nxt    = write_q;
    rdata_nxt    = rdata_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = ISSUE;
          last_nxt     = win;
          gnt_nxt      = NUM_REQ'(1) << win;
          addr_nxt     = addr_sel;
          wdata_nxt    = wdata_sel;
          write_nxt    = write_sel;
          transfer_nxt = 1'b1;
        end
      end
      ISSUE: state_nxt = SETUP;
      // The slave's PREADY may already be high during the master's SETUP phase.
      SETUP: state_nxt = WAIT;
      WAIT: begin
        if (bus.ready) begin
          rdata_nxt = bus.rdata;
          done_nxt  = gnt_q;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      last       <= LW'(NUM_REQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      transfer_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      gnt_q      <= gnt_nxt;
      done_q     <= done_nxt;
      transfer_q <= transfer_nxt;
      write_q    <= write_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      rdata_q    <= rdata_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.transfer  = transfer_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.write     = write_q;
  assign bus.req_rdata = rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter that shares the single APB master internal port (transfer/ready/addr/wdata/write/rdata) between NUM_REQ requesters, e.g. CPU core and DMA/UART-TX feeder.
- Sits between the requesters and the APB master.
- Sequences one APB transaction at a time, masks the master's ready during the master's SETUP phase, and returns read data and a completion pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level; bit i = requester i.
- req_addr  in  NUM_REQ*AW  packed addresses; slice i = [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data, same packing.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- gnt  out  NUM_REQ  one-hot, high for the whole owned transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_rdata  out  DW  read data; valid in the done cycle, held until the next done.
- busy  out  1  high when state is not IDLE.
- transfer  out  1  to master: one-cycle start pulse.
- addr  out  AW  to master.
- wdata  out  DW  to master.
- write  out  1  to master.
- ready  in  1  from master (slave PREADY mux).
- rdata  in  DW  from master (slave PRDATA mux).

Behaviour:
- All outputs are registered except busy, which is decoded from the state.
- Reset (sync, PRESET high at a PCLK edge):
  - state = IDLE.
  - gnt = 0, done = 0, transfer = 0.
  - addr, wdata, req_rdata = 0; write = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts immediately with no done pulse. The master shares PRESET.
- States: IDLE, ISSUE, SETUP, WAIT, DONE.
- IDLE:
  - If req != 0, pick the winner: the first set bit searching from last+1 upward, with wrap-around.
  - Set gnt to the winner (one-hot), set last = winner.
  - Latch the winner's addr/wdata/write into the output registers, and set transfer = 1 for the next cycle.
  - Go to ISSUE. If req == 0, stay in IDLE.
- ISSUE:
  - transfer = 1 this cycle only. The master samples it while in its IDLE state.
  - Next state: SETUP, with transfer cleared.
- SETUP:
  - Covers the master's SETUP phase. ready is ignored here, because a slave PREADY may already be high.
  - Next state: WAIT.
- WAIT:
  - Covers the master's ACCESS phase. Stays here while ready = 0; no timeout.
  - On ready = 1: capture req_rdata = rdata (reads and writes alike), then go to DONE.
- DONE:
  - done[winner] = 1 for exactly this cycle; gnt stays high through this cycle.
  - Next state: IDLE, with gnt = 0 and done = 0.
- Latency:
  - req seen in IDLE at cycle T: transfer at T+1, master SETUP at T+2, ACCESS at T+3.
  - With a zero-wait slave, done is at T+4.
  - Back-to-back transactions: the next transfer is no earlier than done+2.
- Requester rules:
  - Hold req and payload until done. The arbiter latches the payload at grant, so later payload changes are ignored.
  - Dropping req mid-transaction does not cancel it; done still pulses.
  - req still high in the cycle after done is treated as a new request and re-arbitrated with round-robin fairness, so another pending requester wins first.
- Simultaneous events:
  - Requests arriving while busy wait; arbitration happens only in IDLE.
  - All requesters asserted together are served in rotation 0, 1, ..., NUM_REQ-1, 0, ...
- Invariants:
  - gnt has at most one bit set.
  - done is a subset of gnt.
  - transfer is high only in ISSUE.
  - addr, wdata and write are stable from ISSUE through DONE.

Test Plan:
- Reset, then req=2'b01 read of addr 0x1000_1004, slave ready in the first ACCESS cycle with rdata 0xDEAD_BEEF → transfer at T+1, done[0] at T+4, req_rdata = 0xDEAD_BEEF, gnt=2'b01 from T+1 through T+4.
- req=2'b11 held continuously, both writes (r0 → 0x1000_0000 data 0x11, r1 → 0x1000_2000 data 0x22) → grants alternate 0, 1, 0, 1; each transfer carries that requester's addr/wdata with write = 1.
- Slave inserts 3 wait states, with ready already high during the master's SETUP cycle → arbiter ignores ready in SETUP; done arrives exactly 3 cycles later than the zero-wait case.
- r1 asserts req during r0's WAIT → r1 is granted only after r0's done; its transfer occurs at r0 done+2.
- PRESET pulsed during WAIT → next cycle: state IDLE, gnt = 0, done never pulses, last = NUM_REQ-1; a pending req=2'b10 is then granted to r1.
- r0 changes req_addr and drops req during SETUP → transaction completes on the originally latched address and done[0] still pulses.
